// File: rtl/cache_refill_ctrl.sv
// Refill sequencer for the direct-mapped data cache: block refill on load miss,
// write-through/no-allocate stores, and hit/miss performance counters.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | accept cpu requests; hits answered from the cache directly
// RD_REQ  | present read request for the current beat until accepted
// RD_WAIT | wait for read data of the current beat
// FILL    | one-cycle whole-block write into the cache
// RESP    | return the missed word from the fill buffer, release stall
// WR_REQ  | forward the latched store to memory until accepted
module cache_refill_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30,
  parameter int BLOCK_SIZE    = 3,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cpu_req,
  input  logic                                 cpu_we,
  input  logic [ADDRESS_WIDTH-1:0]             cpu_addr,
  input  logic [DATA_WIDTH-1:0]                cpu_wdata,
  output logic [DATA_WIDTH-1:0]                cpu_rdata,
  output logic                                 stall,
  input  logic                                 cache_hit,
  input  logic [DATA_WIDTH-1:0]                cache_rdata,
  output logic                                 cache_wr_en,
  output logic                                 cache_fill_en,
  output logic [DATA_WIDTH*(2**BLOCK_SIZE)-1:0] cache_fill_data,
  output logic                                 mem_req,
  output logic                                 mem_we,
  output logic [ADDRESS_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  input  logic                                 mem_ready,
  input  logic                                 mem_rvalid,
  input  logic [DATA_WIDTH-1:0]                mem_rdata,
  output logic [CNT_WIDTH-1:0]                 hit_count,
  output logic [CNT_WIDTH-1:0]                 miss_count
);

  localparam int S = 2**BLOCK_SIZE;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    FILL    = 3'd3,
    RESP    = 3'd4,
    WR_REQ  = 3'd5
  } state_t;

  state_t                                  state;
  logic [BLOCK_SIZE-1:0]                   beat;
  logic [BLOCK_SIZE-1:0]                   offset;
  logic [ADDRESS_WIDTH-BLOCK_SIZE-1:0]     blk_addr;
  logic [ADDRESS_WIDTH-1:0]                wr_addr;
  logic [DATA_WIDTH-1:0]                   wr_data;
  logic [S-1:0][DATA_WIDTH-1:0]            fill_buf;
  logic                                    idle_req;

  // Requests are masked while reset is held so every output reads zero.
  assign idle_req        = cpu_req && !rst;
  assign cache_fill_data = fill_buf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= '0;
      offset     <= '0;
      blk_addr   <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      fill_buf   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (cache_hit)
              hit_count <= hit_count + CNT_WIDTH'(1);
            if (cpu_we) begin
              wr_addr <= cpu_addr;
              wr_data <= cpu_wdata;
              state   <= WR_REQ;
            end else if (!cache_hit) begin
              miss_count <= miss_count + CNT_WIDTH'(1);
              blk_addr   <= cpu_addr[ADDRESS_WIDTH-1:BLOCK_SIZE];
              offset     <= cpu_addr[BLOCK_SIZE-1:0];
              beat       <= '0;
              state      <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (mem_ready)
            state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (mem_rvalid) begin
            fill_buf[beat] <= mem_rdata;
            if (&beat) begin
              state <= FILL;
            end else begin
              beat  <= beat + 1'b1;
              state <= RD_REQ;
            end
          end
        end
        FILL:    state <= RESP;
        RESP:    state <= IDLE;
        WR_REQ: begin
          if (mem_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall         = 1'b1;
    cpu_rdata     = '0;
    cache_wr_en   = 1'b0;
    cache_fill_en = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state)
      IDLE: begin
        stall       = idle_req && (cpu_we || !cache_hit);
        cache_wr_en = idle_req && cpu_we && cache_hit;
        if (idle_req && !cpu_we && cache_hit)
          cpu_rdata = cache_rdata;
      end
      RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {blk_addr, beat};
      end
      RD_WAIT: ;
      FILL:    cache_fill_en = 1'b1;
      RESP: begin
        stall     = 1'b0;
        cpu_rdata = fill_buf[offset];
      end
      WR_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        stall     = !mem_ready;
      end
      default: stall = 1'b0;
    endcase
  end

endmodule
